// File: rtl/fc_pkg.sv
// fc_pkg: shared types and helpers for the fully-connected layer sequencer.
package fc_pkg;

    typedef enum logic [1:0] {
        LOAD,
        EVAL,
        EMIT
    } state_t;

    function automatic int acc_width(input int width, input int n);
        return 2 * width + $clog2(n);
    endfunction

    // Logical right shift then saturate to an unsigned width-bit range.
    function automatic logic [63:0] requant(input logic [63:0] z, input int shift, input int width);
        logic [63:0] q;
        logic [63:0] max;
        q   = z >> shift;
        max = (64'd1 << width) - 64'd1;
        return (q > max) ? max : q;
    endfunction

endpackage

// File: rtl/fc_requant.sv
// fc_requant: combinational shift/saturate of a neuron result down to activation width.
module fc_requant
    import fc_pkg::*;
#(
    parameter int ACC_W = 23,
    parameter int WIDTH = 8,
    parameter int SHIFT = 8
) (
    input  logic [ACC_W-1:0] z,
    output logic [WIDTH-1:0] q
);

    assign q = WIDTH'(requant(64'(z), SHIFT, WIDTH));

endmodule

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: loads an activation vector serially, then evaluates and streams
// each neuron of one fully-connected layer in turn through an external mux.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IN     = 128,
    parameter int OUT    = 10,
    parameter int SHIFT  = 8,
    parameter int SETTLE = 2,
    localparam int ACC_W = acc_width(WIDTH, IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic [IN*WIDTH-1:0]     x_vec,
    output logic [$clog2(OUT)-1:0]  neuron_sel,
    input  logic [ACC_W-1:0]        z_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic                    busy
);

    localparam int CW = $clog2(IN);
    localparam int NW = $clog2(OUT);
    localparam int SW = $clog2(SETTLE + 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   in_cnt;
    logic [SW-1:0]   settle_cnt;
    logic [WIDTH-1:0] q;
    logic            in_fire, out_fire, last_in, settled, last_neuron;

    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign last_in     = in_cnt == CW'(IN - 1);
    assign settled     = settle_cnt == SW'(SETTLE - 1);
    assign last_neuron = neuron_sel == NW'(OUT - 1);

    fc_requant #(
        .ACC_W (ACC_W),
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_requant (
        .z (z_in),
        .q (q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_fire && last_in) state_nxt = EVAL;
            EVAL:    if (settled) state_nxt = EMIT;
            EMIT:    if (out_fire) state_nxt = last_neuron ? LOAD : EVAL;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        in_ready = state == LOAD;
        busy     = state != LOAD;
    end

    // x_vec and neuron_sel only move in LOAD or on a result handshake, so the
    // external datapath sees a stable operand for the whole settle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt     <= '0;
            x_vec      <= '0;
            neuron_sel <= '0;
            settle_cnt <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else begin
            if (in_fire) begin
                x_vec[in_cnt*WIDTH +: WIDTH] <= in_data;
                in_cnt <= last_in ? '0 : in_cnt + 1'b1;
                if (last_in) begin
                    neuron_sel <= '0;
                    settle_cnt <= '0;
                end
            end
            if (state == EVAL) begin
                settle_cnt <= settle_cnt + 1'b1;
                if (settled) begin
                    out_valid <= 1'b1;
                    out_data  <= q;
                    out_last  <= last_neuron;
                end
            end
            if (state == EMIT && out_fire) begin
                out_valid  <= 1'b0;
                out_last   <= 1'b0;
                settle_cnt <= '0;
                neuron_sel <= last_neuron ? '0 : neuron_sel + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: directed/random stimulus against a reference model of the sequencer.
module tb_fc_layer_sequencer;

    localparam int WIDTH  = 8;
    localparam int IN     = 128;
    localparam int OUT    = 10;
    localparam int SHIFT  = 8;
    localparam int SETTLE = 2;
    localparam int ACC_W  = 2 * WIDTH + $clog2(IN);
    localparam int NW     = $clog2(OUT);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data = '0;
    logic [IN*WIDTH-1:0] x_vec;
    logic [IN*WIDTH-1:0] exp_vec = '0;
    logic [NW-1:0]       neuron_sel;
    logic [ACC_W-1:0]    z_in;
    logic [ACC_W-1:0]    z_tab [0:15];
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [WIDTH-1:0]    out_data;
    logic                out_last;
    logic                busy;
    int                  errors = 0;
    int                  checks = 0;

    always #5 clk = ~clk;

    // The bench plays the external neuron mux.
    assign z_in = z_tab[neuron_sel];

    fc_layer_sequencer #(
        .WIDTH  (WIDTH),
        .IN     (IN),
        .OUT    (OUT),
        .SHIFT  (SHIFT),
        .SETTLE (SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .x_vec      (x_vec),
        .neuron_sel (neuron_sel),
        .z_in       (z_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_q(input logic [ACC_W-1:0] z);
        longint unsigned v;
        v = longint'(z) / (longint'(1) << SHIFT);
        return (v > 255) ? 64'd255 : 64'(v);
    endfunction

    task automatic load_vec(input bit ramp);
        int n = 0;
        int c = 0;
        while (n < IN && c < 4 * IN) begin
            logic [WIDTH-1:0] d;
            bit acc;
            d        = ramp ? WIDTH'(n) : WIDTH'($urandom);
            in_valid = ramp ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_data  = d;
            acc      = in_valid && in_ready;
            @(negedge clk);
            if (acc) begin
                exp_vec[n*WIDTH +: WIDTH] = d;
                n++;
            end
            c++;
        end
        in_valid = 1'b0;
        check("load_count", 64'(n), 64'(IN));
        check("in_ready_after_load", 64'(in_ready), 64'd0);
        check("busy_after_load", 64'(busy), 64'd1);
        check("x_vec_match", 64'(x_vec === exp_vec), 64'd1);
    endtask

    task automatic run_layer(input int stall_at, input int abort_at);
        for (int j = 0; j < OUT; j++) begin
            int k = 0;
            while (!out_valid && k < 20) begin
                in_valid = $urandom_range(0, 1);
                in_data  = WIDTH'($urandom);
                @(negedge clk);
                k++;
            end
            check("latency", 64'(k), 64'(SETTLE));
            check("neuron_sel", 64'(neuron_sel), 64'(j));
            check("out_data", 64'(out_data), ref_q(z_tab[j]));
            check("out_last", 64'(out_last), 64'(j == OUT - 1));
            if (j == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_out_valid", 64'(out_valid), 64'd0);
                check("abort_x_vec", 64'(x_vec == '0), 64'd1);
                check("abort_in_ready", 64'(in_ready), 64'd1);
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_sel", 64'(neuron_sel), 64'd0);
                @(negedge clk);
                rst_n    = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                check("abort_no_emit", 64'(out_valid), 64'd0);
                return;
            end
            repeat ((j == stall_at) ? 5 : $urandom_range(0, 2)) begin
                in_valid = $urandom_range(0, 1);
                @(negedge clk);
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), ref_q(z_tab[j]));
                check("hold_last", 64'(out_last), 64'(j == OUT - 1));
                check("hold_sel", 64'(neuron_sel), 64'(j));
            end
            out_ready = 1'b1;
            in_valid  = $urandom_range(0, 1);
            @(negedge clk);
            out_ready = 1'b0;
            check("valid_drop", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0;
        check("done_in_ready", 64'(in_ready), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_sel", 64'(neuron_sel), 64'd0);
        check("done_last", 64'(out_last), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) z_tab[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_sel", 64'(neuron_sel), 64'd0);
        check("rst_x_vec", 64'(x_vec == '0), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        load_vec(1'b1);
        check("x_elem5", 64'(x_vec[5*WIDTH +: WIDTH]), 64'd5);
        check("x_elem127", 64'(x_vec[127*WIDTH +: WIDTH]), 64'd127);
        z_tab[0] = ACC_W'(32'h1234);
        z_tab[1] = ACC_W'(32'h30000);
        z_tab[2] = '0;
        z_tab[3] = ACC_W'(32'hFFFF);
        z_tab[4] = ACC_W'(32'h10000);
        z_tab[5] = '1;
        for (int i = 6; i < OUT; i++) z_tab[i] = ACC_W'($urandom);
        run_layer(3, -1);
        for (int i = 0; i < OUT; i++) z_tab[i] = ACC_W'($urandom) >> $urandom_range(0, 12);
        load_vec(1'b0);
        run_layer(-1, 4);
        for (int i = 0; i < OUT; i++) z_tab[i] = ACC_W'($urandom) >> $urandom_range(0, 12);
        load_vec(1'b0);
        run_layer(7, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
